// File: rtl/median_pkg.sv
// Shared types and constants for the serial median feeder and its result slot.
package median_pkg;

  localparam int N_TAPS = 9;
  localparam int W_DEF  = 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAPW} feed_state_t;

endpackage

// File: rtl/median_result_slot.sv
// One-entry W-bit result register: load sets valid the next cycle, valid holds until MED_READY.
// Load and drain never coincide because the feeder only starts a window when the slot is empty or draining.
module median_result_slot
  import median_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic [W-1:0] MED_O,
  output logic         MED_VALID,
  input  logic         MED_READY
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      MED_O     <= '0;
      MED_VALID <= 1'b0;
    end else if (load) begin
      MED_O     <= data;
      MED_VALID <= 1'b1;
    end else if (MED_VALID && MED_READY) begin
      MED_VALID <= 1'b0;
    end
  end

endmodule

// File: rtl/median_window_feeder.sv
// Serializes a 3x3 window into 9 DSI strobes (first strobe the cycle after accept), waits for DSO, then
// offers the median on a valid/ready slot; WIN_READY is low unless idle with the slot empty or draining.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int GAP = 2,
  parameter int TMO = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [N_TAPS*W-1:0] WIN_I,
  input  logic              WIN_VALID,
  output logic              WIN_READY,
  output logic [W-1:0]      DI_O,
  output logic              DSI_O,
  input  logic [W-1:0]      DO_I,
  input  logic              DSO_I,
  output logic [W-1:0]      MED_O,
  output logic              MED_VALID,
  input  logic              MED_READY,
  output logic              ERR
);

  localparam int WCW = $clog2(TMO);
  localparam int GCW = $clog2(GAP + 1);

  localparam logic [3:0]     LAST_TAP = 4'(N_TAPS - 1);
  localparam logic [WCW-1:0] WC_MAX   = WCW'(TMO - 1);
  localparam logic [WCW-1:0] WC_TRIP  = WCW'(TMO - 2);
  localparam logic [GCW-1:0] GC_MAX   = GCW'(GAP);
  localparam logic [GCW-1:0] GC_DONE  = GCW'(GAP - 1);

  feed_state_t         state, state_nxt;
  logic                armed;
  logic [N_TAPS*W-1:0] taps;
  logic [3:0]          tap_cnt;
  logic [WCW-1:0]      wait_cnt;
  logic [GCW-1:0]      gap_cnt;
  logic                accept, last_tap, got_dso, timeout, gap_done;

  // armed keeps WIN_READY low while nRST is asserted, even though IDLE would otherwise allow it
  assign WIN_READY = armed && (state == IDLE) && (!MED_VALID || MED_READY);
  assign accept    = WIN_VALID && WIN_READY;
  assign last_tap  = (state == SEND) && (tap_cnt == LAST_TAP);
  assign got_dso   = (state == WAIT) && DSO_I;
  // fires on the cycle the wait counter would reach TMO-1; a coincident DSO takes priority
  assign timeout   = (state == WAIT) && !DSO_I && (wait_cnt == WC_TRIP);
  // gap_cnt holds completed low cycles; the current GAPW cycle makes up the rest
  assign gap_done  = (gap_cnt >= GC_DONE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)             state_nxt = SEND;
      SEND:    if (last_tap)           state_nxt = WAIT;
      WAIT:    if (got_dso || timeout) state_nxt = GAPW;
      GAPW:    if (gap_done)           state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      armed    <= 1'b0;
      taps     <= '0;
      tap_cnt  <= '0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      DI_O     <= '0;
      DSI_O    <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        DI_O     <= WIN_I[W-1:0];
        DSI_O    <= 1'b1;
        taps     <= WIN_I >> W;
        tap_cnt  <= '0;
        wait_cnt <= '0;
        gap_cnt  <= '0;
      end else if (state == SEND) begin
        if (last_tap) begin
          DI_O  <= '0;
          DSI_O <= 1'b0;
        end else begin
          DI_O    <= taps[W-1:0];
          taps    <= taps >> W;
          tap_cnt <= tap_cnt + 4'd1;
        end
      end
      if ((state == WAIT) && (wait_cnt != WC_MAX)) wait_cnt <= wait_cnt + 1'b1;
      if (((state == WAIT) || (state == GAPW)) && (gap_cnt != GC_MAX)) gap_cnt <= gap_cnt + 1'b1;
      if (timeout) ERR <= 1'b1;
    end
  end

  median_result_slot #(.W(W)) u_slot (
    .CLK       (CLK),
    .nRST      (nRST),
    .load      (got_dso),
    .data      (DO_I),
    .MED_O     (MED_O),
    .MED_VALID (MED_VALID),
    .MED_READY (MED_READY)
  );

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder with a behavioural engine stub that can reply late, never, or with a real median.
module tb_median_window_feeder;

  localparam int W   = 8;
  localparam int GAP = 2;
  localparam int TMO = 64;

  logic         CLK;
  logic         nRST;
  logic [71:0]  WIN_I;
  logic         WIN_VALID;
  logic         WIN_READY;
  logic [W-1:0] DI_O;
  logic         DSI_O;
  logic [W-1:0] DO_I;
  logic         DSO_I;
  logic [W-1:0] MED_O;
  logic         MED_VALID;
  logic         MED_READY;
  logic         ERR;

  int vectors;
  int miscompares;

  // stub_mode: 0 = never reply, 1 = reply stub_val, 2 = reply the true median of the burst
  int           stub_mode;
  int           stub_delay;
  logic [7:0]   stub_val;
  logic [7:0]   sbuf [9];
  int           scnt;
  int           sdly;

  median_window_feeder #(.W(W), .GAP(GAP), .TMO(TMO)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .WIN_I     (WIN_I),
    .WIN_VALID (WIN_VALID),
    .WIN_READY (WIN_READY),
    .DI_O      (DI_O),
    .DSI_O     (DSI_O),
    .DO_I      (DO_I),
    .DSO_I     (DSO_I),
    .MED_O     (MED_O),
    .MED_VALID (MED_VALID),
    .MED_READY (MED_READY),
    .ERR       (ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  function automatic logic [71:0] pack9(input logic [7:0] t [9]);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = t[k];
    return r;
  endfunction

  function automatic logic [7:0] med9(input logic [7:0] s [9]);
    logic [7:0] a [9];
    logic [7:0] tmp;
    a = s;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp;
        end
    return a[4];
  endfunction

  // engine stub: counts DSI strobes and pulses DSO stub_delay+1 cycles after the 9th
  always @(negedge CLK) begin
    DSO_I = 1'b0;
    if (nRST !== 1'b1) begin
      scnt = 0;
      sdly = -1;
      DO_I = '0;
    end else begin
      if (sdly == 0) begin
        DSO_I = 1'b1;
        DO_I  = (stub_mode == 2) ? med9(sbuf) : stub_val;
        sdly  = -1;
      end else if (sdly > 0) begin
        sdly--;
      end
      if (DSI_O === 1'b1) begin
        sbuf[scnt] = DI_O;
        scnt++;
        if (scnt == 9) begin
          scnt = 0;
          if (stub_mode != 0) sdly = stub_delay;
        end
      end
    end
  end

  // called at a negedge; returns at the negedge after the accepting edge (first sample on DI_O)
  task automatic send_window(input logic [71:0] w, output bit ok);
    ok = 1'b0;
    WIN_I = w;
    WIN_VALID = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (WIN_READY === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    WIN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    WIN_I = '0;
    WIN_VALID = 1'b0;
    MED_READY = 1'b0;
    stub_mode = 0;
    stub_delay = 0;
    stub_val = '0;
    repeat (3) @(negedge CLK);
    vectors++; if (WIN_READY !== 1'b0) begin miscompares++; $display("FAIL rst_win_ready got %b want 0", WIN_READY); end
    vectors++; if (DSI_O !== 1'b0) begin miscompares++; $display("FAIL rst_dsi got %b want 0", DSI_O); end
    vectors++; if (DI_O !== 8'd0) begin miscompares++; $display("FAIL rst_di got %0d want 0", DI_O); end
    vectors++; if (MED_VALID !== 1'b0) begin miscompares++; $display("FAIL rst_med_valid got %b want 0", MED_VALID); end
    vectors++; if (MED_O !== 8'd0) begin miscompares++; $display("FAIL rst_med_o got %0d want 0", MED_O); end
    vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", ERR); end
    nRST = 1'b1;
    @(negedge CLK);
    vectors++; if (WIN_READY !== 1'b1) begin miscompares++; $display("FAIL post_rst_ready got %b want 1", WIN_READY); end
  endtask

  task automatic test_basic();
    logic [7:0] tv [9];
    bit ok;
    int n;
    tv = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    stub_mode = 1; stub_delay = 20; stub_val = 8'd5; MED_READY = 1'b0;
    send_window(pack9(tv), ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL basic_accept got %b want 1", ok); end
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (DSI_O !== 1'b1 || DI_O !== tv[k]) begin
        miscompares++;
        $display("FAIL basic_tap%0d got dsi=%b di=%0d want dsi=1 di=%0d", k, DSI_O, DI_O, tv[k]);
      end
      @(negedge CLK);
    end
    vectors++; if (DSI_O !== 1'b0) begin miscompares++; $display("FAIL basic_burst_end got dsi=%b want 0", DSI_O); end
    n = 0;
    while (MED_VALID !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    vectors++; if (n !== 21) begin miscompares++; $display("FAIL basic_med_latency got %0d want 21", n); end
    vectors++; if (MED_O !== 8'd5) begin miscompares++; $display("FAIL basic_med_o got %0d want 5", MED_O); end
    vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL basic_err got %b want 0", ERR); end
  endtask

  task automatic test_backpressure();
    logic [7:0] tv [9];
    int n;
    tv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    stub_mode = 1; stub_delay = 2; stub_val = 8'd3;
    WIN_I = pack9(tv);
    WIN_VALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      vectors++;
      if (WIN_READY !== 1'b0 || MED_O !== 8'd5 || MED_VALID !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold%0d got ready=%b med=%0d vld=%b want 0/5/1", c, WIN_READY, MED_O, MED_VALID);
      end
    end
    MED_READY = 1'b1;
    #1;
    vectors++; if (WIN_READY !== 1'b1) begin miscompares++; $display("FAIL bp_ready_on_drain got %b want 1", WIN_READY); end
    @(negedge CLK);
    WIN_VALID = 1'b0;
    vectors++;
    if (MED_VALID !== 1'b0 || DSI_O !== 1'b1 || DI_O !== tv[0]) begin
      miscompares++;
      $display("FAIL bp_same_edge got vld=%b dsi=%b di=%0d want 0/1/%0d", MED_VALID, DSI_O, DI_O, tv[0]);
    end
    n = 0;
    while (MED_VALID !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    vectors++; if (MED_O !== 8'd3 || MED_VALID !== 1'b1) begin miscompares++; $display("FAIL bp_second_med got %0d vld=%b want 3", MED_O, MED_VALID); end
  endtask

  task automatic test_timeout();
    logic [7:0] tv [9];
    bit ok;
    int n, s;
    tv = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    stub_mode = 0; MED_READY = 1'b1;
    send_window(pack9(tv), ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL tmo_accept got %b want 1", ok); end
    for (int k = 0; k < 9; k++) begin
      vectors++; if (DSI_O !== 1'b1) begin miscompares++; $display("FAIL tmo_strobe%0d got %b want 1", k, DSI_O); end
      if (k < 8) @(negedge CLK);
    end
    n = 0;
    while (ERR !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
    vectors++; if (n !== 64) begin miscompares++; $display("FAIL tmo_err_delay got %0d want 64", n); end
    vectors++; if (MED_VALID !== 1'b0) begin miscompares++; $display("FAIL tmo_med_valid got %b want 0", MED_VALID); end
    stub_mode = 1; stub_delay = 3; stub_val = 8'h42;
    send_window(pack9(tv), ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL tmo_next_accept got %b want 1", ok); end
    s = 0;
    for (int c = 0; c < 12; c++) begin
      if (DSI_O === 1'b1) s++;
      @(negedge CLK);
    end
    vectors++; if (s !== 9) begin miscompares++; $display("FAIL tmo_next_strobes got %0d want 9", s); end
    n = 0;
    while (MED_VALID !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    vectors++; if (MED_O !== 8'h42 || MED_VALID !== 1'b1) begin miscompares++; $display("FAIL tmo_next_med got %0d vld=%b want 66", MED_O, MED_VALID); end
    vectors++; if (ERR !== 1'b1) begin miscompares++; $display("FAIL tmo_err_sticky got %b want 1", ERR); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tv [9];
    int acc, bursts, hi, lo;
    logic prev;
    bit drop;
    tv = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
    stub_mode = 1; stub_delay = 0; stub_val = 8'h11; MED_READY = 1'b1;
    WIN_I = pack9(tv);
    WIN_VALID = 1'b1;
    acc = 0; bursts = 0; hi = 0; lo = 0; prev = 1'b0; drop = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (drop) WIN_VALID = 1'b0;
      if (WIN_VALID === 1'b1 && WIN_READY === 1'b1) begin
        acc++;
        if (acc == 3) drop = 1'b1;
      end
      if (DSI_O === 1'b1) begin
        if (!prev) begin
          if (bursts > 0) begin
            vectors++; if (lo < GAP) begin miscompares++; $display("FAIL b2b_gap%0d got %0d low cycles want >=%0d", bursts, lo, GAP); end
          end
          lo = 0;
        end
        hi++;
      end else begin
        if (prev) begin
          bursts++;
          vectors++; if (hi !== 9) begin miscompares++; $display("FAIL b2b_burst%0d got %0d strobes want 9", bursts, hi); end
          hi = 0;
        end
        lo++;
      end
      prev = DSI_O;
      @(negedge CLK);
    end
    vectors++; if (bursts !== 3) begin miscompares++; $display("FAIL b2b_bursts got %0d want 3", bursts); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] tv [9];
    bit ok;
    int n;
    tv = '{8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29};
    stub_mode = 1; stub_delay = 2; stub_val = 8'h77; MED_READY = 1'b1;
    send_window(pack9(tv), ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rm_accept got %b want 1", ok); end
    repeat (4) @(negedge CLK);
    vectors++; if (DSI_O !== 1'b1 || DI_O !== tv[4]) begin miscompares++; $display("FAIL rm_fifth got dsi=%b di=%0d want 1/%0d", DSI_O, DI_O, tv[4]); end
    #1 nRST = 1'b0;
    #1;
    vectors++;
    if (DSI_O !== 1'b0 || DI_O !== 8'd0 || WIN_READY !== 1'b0 || MED_VALID !== 1'b0 || ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_async got dsi=%b di=%0d rdy=%b vld=%b err=%b want all 0", DSI_O, DI_O, WIN_READY, MED_VALID, ERR);
    end
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    send_window(pack9(tv), ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rm_reaccept got %b want 1", ok); end
    for (int k = 0; k < 9; k++) begin
      vectors++;
      if (DSI_O !== 1'b1 || DI_O !== tv[k]) begin
        miscompares++;
        $display("FAIL rm_tap%0d got dsi=%b di=%0d want 1/%0d", k, DSI_O, DI_O, tv[k]);
      end
      @(negedge CLK);
    end
    vectors++; if (DSI_O !== 1'b0) begin miscompares++; $display("FAIL rm_burst_end got %b want 0", DSI_O); end
    n = 0;
    while (MED_VALID !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    vectors++; if (MED_O !== 8'h77 || MED_VALID !== 1'b1) begin miscompares++; $display("FAIL rm_med got %0d vld=%b want 119", MED_O, MED_VALID); end
  endtask

  task automatic test_median();
    logic [7:0] wa [9];
    logic [7:0] wb [9];
    logic [7:0] wc [9];
    logic [71:0] win [3];
    logic [7:0] want [3];
    bit ok;
    int n;
    wa = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd255, 8'd255, 8'd0};
    wb = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
    wc = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    win[0] = pack9(wa); want[0] = 8'd255;
    win[1] = pack9(wb); want[1] = 8'd7;
    win[2] = pack9(wc); want[2] = 8'd4;
    stub_mode = 2; stub_delay = 5; MED_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_window(win[i], ok);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL med%0d_accept got %b want 1", i, ok); end
      n = 0;
      while (MED_VALID !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
      vectors++; if (MED_O !== want[i] || MED_VALID !== 1'b1) begin miscompares++; $display("FAIL med%0d_value got %0d vld=%b want %0d", i, MED_O, MED_VALID, want[i]); end
      vectors++; if (ERR !== 1'b0) begin miscompares++; $display("FAIL med%0d_err got %b want 0", i, ERR); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_median();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
